// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store unit with read-modify-write for sub-doubleword stores
module load_store_unit #(
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } state_t;

    state_t      state;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic        addr_oob;

    assign addr_oob = (req_addr >> ADDR_BITS) != 64'd0;

    // Memory is big-endian: the addressed byte sits in mem_rdata[63:56].
    function automatic logic [63:0] extract(input logic [1:0]  size,
                                            input logic        uns,
                                            input logic [63:0] rd);
        logic [63:0] r;
        r = rd;
        case (size)
            2'b00:   r = uns ? {56'd0, rd[63:56]} : {{56{rd[63]}}, rd[63:56]};
            2'b01:   r = uns ? {48'd0, rd[63:48]} : {{48{rd[63]}}, rd[63:48]};
            2'b10:   r = uns ? {32'd0, rd[63:32]} : {{32{rd[63]}}, rd[63:32]};
            default: r = rd;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] merge(input logic [1:0]  size,
                                          input logic [63:0] wd,
                                          input logic [63:0] rd);
        logic [63:0] r;
        r = wd;
        case (size)
            2'b00:   r = {wd[7:0],  rd[55:0]};
            2'b01:   r = {wd[15:0], rd[47:0]};
            2'b10:   r = {wd[31:0], rd[31:0]};
            default: r = wd;
        endcase
        return r;
    endfunction

    assign req_ready  = (state == IDLE);
    assign mem_read   = (state == LOAD) || (state == RMW_RD);
    assign mem_write  = (state == WRITE);
    assign resp_valid = (state == RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            mem_addr     <= 64'd0;
            mem_wdata    <= 64'd0;
            resp_rdata   <= 64'd0;
            resp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mem_addr     <= req_addr;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        mem_wdata    <= req_wdata;
                        if (addr_oob) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= 64'd0;
                            state      <= RESP;
                        end else if (req_load) begin
                            state <= LOAD;
                        end else if (req_size == 2'b11) begin
                            state <= WRITE;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    resp_rdata <= extract(lat_size, lat_unsigned, mem_rdata);
                    resp_err   <= 1'b0;
                    state      <= RESP;
                end
                RMW_RD: begin
                    // mem_wdata still holds the right-justified store data here.
                    mem_wdata <= merge(lat_size, mem_wdata, mem_rdata);
                    state     <= WRITE;
                end
                WRITE: begin
                    resp_rdata <= 64'd0;
                    resp_err   <= 1'b0;
                    state      <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - table-driven scoreboard bench for load_store_unit
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    load_store_unit #(.ADDR_BITS(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_load     (req_load),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    typedef struct {
        logic        load;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [63:0] addr;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    logic [7:0] mem [0:1023];
    vec_t vecs [18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, req);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte memory: zero except 80 01 02 03 04 05 06 07 at 0x10.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
            for (int i = 0; i < 8; i++) mem[16 + i] <= (i == 0) ? 8'h80 : 8'(i);
        end else if (mem_write) begin
            for (int i = 0; i < 8; i++)
                mem[(int'(mem_addr[9:0]) + i) & 1023] <= mem_wdata[63 - 8 * i -: 8];
        end
    end

    always_comb begin
        mem_rdata = 64'd0;
        for (int i = 0; i < 8; i++)
            mem_rdata[63 - 8 * i -: 8] = mem[(int'(mem_addr[9:0]) + i) & 1023];
    end

    // Monitor: tracks accepts, strobe counts and pops the scoreboard on each response.
    initial begin
        int   acc_cyc;
        int   rd_cnt;
        int   wr_cnt;
        exp_t e;
        acc_cyc = 0;
        rd_cnt  = 0;
        wr_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                rd_cnt = 0;
                wr_cnt = 0;
            end else begin
                if (req_valid && req_ready) begin
                    acc_cyc = cyc;
                    rd_cnt  = 0;
                    wr_cnt  = 0;
                end
                if (mem_read && mem_write) chk("strobe_overlap", 64'd1, 64'd0);
                if (mem_read)  rd_cnt++;
                if (mem_write) wr_cnt++;
                if (resp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_resp", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("resp_err", 64'(resp_err), 64'(e.err));
                        chk("resp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
                        chk("read_cycles", 64'(rd_cnt), 64'(e.nrd));
                        chk("write_cycles", 64'(wr_cnt), 64'(e.nwr));
                        chk("mem_addr_hold", mem_addr, e.addr);
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic issue(input vec_t v, input bit expect_resp);
        int   n;
        exp_t e;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_before_accept", 64'(req_ready), 64'd1);
        req_valid    = 1'b1;
        req_load     = v.load;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        if (expect_resp) begin
            e.rdata = v.rdata;
            e.err   = v.err;
            e.lat   = v.lat;
            e.nrd   = v.nrd;
            e.nwr   = v.nwr;
            e.addr  = v.addr;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 64'hFFFF_FFFF_FFFF_FFFF;
        req_wdata = 64'hA5A5_A5A5_A5A5_A5A5;
        chk("ready_after_accept", 64'(req_ready), 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        issue(v, 1'b1);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("resp_timeout", 64'd1, 64'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_load     = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 64'd0;
        req_wdata    = 64'd0;

        //          load  size   uns   addr       wdata                   rdata                   err   lat nrd nwr
        vecs[0]  = '{1'b1, 2'b00, 1'b0, 64'h10,    64'd0,                  64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2, 1, 0};
        vecs[1]  = '{1'b1, 2'b01, 1'b1, 64'h10,    64'd0,                  64'h0000_0000_0000_8001, 1'b0, 2, 1, 0};
        vecs[2]  = '{1'b1, 2'b11, 1'b0, 64'h10,    64'd0,                  64'h8001_0203_0405_0607, 1'b0, 2, 1, 0};
        vecs[3]  = '{1'b1, 2'b10, 1'b0, 64'h10,    64'd0,                  64'hFFFF_FFFF_8001_0203, 1'b0, 2, 1, 0};
        vecs[4]  = '{1'b1, 2'b00, 1'b1, 64'h11,    64'd0,                  64'h0000_0000_0000_0001, 1'b0, 2, 1, 0};
        vecs[5]  = '{1'b0, 2'b10, 1'b0, 64'h10,    64'h1234_5678_DEAD_BEEF, 64'd0,                  1'b0, 3, 1, 1};
        vecs[6]  = '{1'b1, 2'b11, 1'b0, 64'h10,    64'd0,                  64'hDEAD_BEEF_0405_0607, 1'b0, 2, 1, 0};
        vecs[7]  = '{1'b0, 2'b00, 1'b0, 64'h14,    64'h9988_7766_5544_33AA, 64'd0,                  1'b0, 3, 1, 1};
        vecs[8]  = '{1'b0, 2'b01, 1'b1, 64'h16,    64'hFFFF_FFFF_FFFF_1234, 64'd0,                  1'b0, 3, 1, 1};
        vecs[9]  = '{1'b1, 2'b11, 1'b0, 64'h10,    64'd0,                  64'hDEAD_BEEF_AA05_1234, 1'b0, 2, 1, 0};
        vecs[10] = '{1'b0, 2'b11, 1'b0, 64'h20,    64'h1122_3344_5566_7788, 64'd0,                  1'b0, 2, 0, 1};
        vecs[11] = '{1'b1, 2'b11, 1'b0, 64'h20,    64'd0,                  64'h1122_3344_5566_7788, 1'b0, 2, 1, 0};
        vecs[12] = '{1'b1, 2'b01, 1'b0, 64'h20,    64'd0,                  64'h0000_0000_0000_1122, 1'b0, 2, 1, 0};
        vecs[13] = '{1'b1, 2'b10, 1'b1, 64'h10,    64'd0,                  64'h0000_0000_DEAD_BEEF, 1'b0, 2, 1, 0};
        vecs[14] = '{1'b1, 2'b10, 1'b0, 64'h10,    64'd0,                  64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 2, 1, 0};
        vecs[15] = '{1'b1, 2'b11, 1'b0, 64'h400,   64'd0,                  64'd0,                  1'b1, 1, 0, 0};
        vecs[16] = '{1'b0, 2'b00, 1'b0, 64'h1000,  64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                  1'b1, 1, 0, 0};
        vecs[17] = '{1'b1, 2'b11, 1'b1, 64'h10,    64'd0,                  64'hDEAD_BEEF_AA05_1234, 1'b0, 2, 1, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_read", 64'(mem_read), 64'd0);
        chk("rst_mem_write", 64'(mem_write), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        reset = 1'b1;
        chk("ready_after_reset", 64'(req_ready), 64'd1);

        for (int i = 0; i < 18; i++) run_vec(vecs[i]);

        chk("mem_0x10_after_word_store", 64'(mem[16]), 64'hDE);
        chk("mem_0x13_after_word_store", 64'(mem[19]), 64'hEF);
        chk("mem_0x17_after_half_store", 64'(mem[23]), 64'h34);

        // Reset while a byte store sits in RMW_RD: nothing may be written or answered.
        begin
            vec_t v;
            v = '{1'b0, 2'b00, 1'b0, 64'h10, 64'h55, 64'd0, 1'b0, 3, 1, 1};
            issue(v, 1'b0);
            chk("rmw_read_strobe", 64'(mem_read), 64'd1);
            reset = 1'b0;
            #1;
            chk("abort_mem_read", 64'(mem_read), 64'd0);
            chk("abort_mem_write", 64'(mem_write), 64'd0);
            chk("abort_resp_valid", 64'(resp_valid), 64'd0);
            repeat (2) @(posedge clk);
            #1;
            chk("abort_resp_rdata", resp_rdata, 64'd0);
            chk("abort_mem_addr", mem_addr, 64'd0);
            reset = 1'b1;
            chk("abort_ready", 64'(req_ready), 64'd1);
            chk("abort_mem_unchanged", 64'(mem[16]), 64'hDE);
            run_vec(vecs[9]);
            repeat (3) @(posedge clk);
            #1;
            chk("resp_rdata_hold", resp_rdata, 64'hDEAD_BEEF_AA05_1234);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_BITS, default 10, implemented data-memory address width; req_addr bits above it must be zero.
REQ-002 clk  input  1  rising-edge clock shared with data memory.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  pipeline MEM-stage request present.
REQ-005 req_ready  output  1  unit idle and able to accept; high only in IDLE.
REQ-006 req_load  input  1  1 = load, 0 = store.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 double (funct3[1:0]).
REQ-008 req_unsigned  input  1  zero-extend load result (funct3[2]); ignored for stores and doubles.
REQ-009 req_addr  input  64  byte address.
REQ-010 req_wdata  input  64  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle pulse: operation complete.
REQ-012 resp_rdata  output  64  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  valid with resp_valid: address out of range.
REQ-014 mem_addr  output  64  data memory address (latched request address).
REQ-015 mem_read  output  1  data memory read enable.
REQ-016 mem_write  output  1  data memory write enable.
REQ-017 mem_wdata  output  64  doubleword written to memory.
REQ-018 mem_rdata  input  64  combinational memory read data; byte at mem_addr in [63:56] (big-endian).

Function
REQ-019 States: IDLE, LOAD, RMW_RD, WRITE, RESP; mem_read/mem_write/req_ready/resp_valid decoded from state only.
REQ-020 Accept on rising edge with req_valid=1 in IDLE; latch load, size, unsigned, addr, wdata; request inputs ignored outside IDLE.
REQ-021 Accept with req_addr[63:ADDR_BITS] nonzero: IDLE->RESP, no memory strobe, resp_err=1, resp_rdata=0.
REQ-022 Load: IDLE->LOAD (mem_read=1) ->RESP; resp_rdata captured at LOAD's closing edge; response 2 cycles after accept.
REQ-023 Load extraction: byte mem_rdata[63:56], half [63:48], word [63:32], double [63:0]; sign-extend unless req_unsigned=1.
REQ-024 Store double: IDLE->WRITE (mem_write=1, mem_wdata=req_wdata) ->RESP; response 2 cycles after accept.
REQ-025 Store byte/half/word: IDLE->RMW_RD (mem_read=1) ->WRITE->RESP; response 3 cycles after accept.
REQ-026 Merge captured in RMW_RD: byte {wdata[7:0],rd[55:0]}, half {wdata[15:0],rd[47:0]}, word {wdata[31:0],rd[31:0]}.
REQ-027 mem_write high for exactly one cycle per store; never with mem_read; never both strobes for loads.
REQ-028 RESP lasts one cycle, then IDLE; earliest next accept is the RESP->IDLE edge's following cycle (no back-to-back overlap).
REQ-029 mem_addr holds latched address from accept until next accept; low ADDR_BITS wrap is memory's behaviour, not the unit's.
REQ-030 resp_rdata, resp_err hold value until next accept's response overwrites them.

Reset
REQ-031 reset low: immediately state=IDLE, req_ready=1 (after reset released), all other outputs 0, latched registers 0.
REQ-032 reset asserted mid-operation aborts it; no pending write completes; no response issued.
REQ-033 First accept allowed on first rising edge after reset deasserted.

Verification
REQ-034 mem[0x10..0x17]=80 01 02 03 04 05 06 07, load byte signed @0x10 -> resp_rdata=0xFFFF_FFFF_FFFF_FF80, resp_valid 2 cycles after accept.
REQ-035 Same memory, load half unsigned @0x10 -> 0x0000_0000_0000_8001; load double -> 0x8001_0203_0405_0607.
REQ-036 Store word 0xDEADBEEF @0x10 over above -> mem reads DE AD BE EF 04 05 06 07; mem_read 1 cycle then mem_write 1 cycle; response 3 cycles after accept.
REQ-037 Store double 0x1122334455667788 @0x20 -> single mem_write cycle, no mem_read, later load double returns same value.
REQ-038 Load @0x400 (ADDR_BITS=10) -> resp_err=1, resp_rdata=0, no strobes, response next cycle after accept+1.
REQ-039 reset pulsed low during WRITE-pending subword store (in RMW_RD) -> strobes drop immediately, memory unchanged, no resp_valid, req_ready=1 after release.
